wave_measure: RTL and testbench

- Receive-side counterpart to the waveform generator: takes 8-bit samples from an ADC, or looped back from the DAC output, and measures the signal period and peak levels.
- Detects rising threshold crossings with hysteresis.
- Counts qualified samples between consecutive rising crossings.
- Reports period, max and min per completed cycle with a one-clock valid pulse; feeds display/UART status logic.

---
 rtl/wave_measure.sv | 185 ++++++++++++++++++
 tb/tb_wave_measure.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_measure.sv
// Period and peak-level measurement of an 8-bit sample stream using hysteresis rising crossings.
// Optional macro WAVE_MEASURE_AUTO_THRESH_EN derives the threshold from tracked signal extremes.
module wave_measure #(
    parameter int CNT_W  = 24,
    parameter int HYST   = 8,
    parameter int THRESH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [7:0]       din,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       vmax,
    output logic [7:0]       vmin,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        ARM    = 2'd1,
        RUN_HI = 2'd2,
        RUN_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [9:0]       HYST_W  = 10'(HYST);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       run_max_q, run_max_d;
    logic [7:0]       run_min_q, run_min_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       vmax_q, vmax_d;
    logic [7:0]       vmin_q, vmin_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q, timeout_d;

    logic [7:0]       thr;
    logic [9:0]       hi_sum;
    logic [7:0]       thr_hi;
    logic [7:0]       thr_lo;
    logic             is_high;
    logic             is_low;

`ifdef WAVE_MEASURE_AUTO_THRESH_EN
    logic [7:0] trk_max_q, trk_max_d;
    logic [7:0] trk_min_q, trk_min_d;
    logic       seen_q, seen_d;

    // The reset tracker pair (0x00/0xFF) is meaningless, so hold THRESH until a sample arrives.
    always_comb begin
        thr = seen_q ? 8'(({1'b0, trk_max_q} + {1'b0, trk_min_q}) >> 1) : 8'(THRESH);
    end

    always_comb begin
        trk_max_d = trk_max_q;
        trk_min_d = trk_min_q;
        seen_d    = seen_q;
        if (sample_en) begin
            seen_d = 1'b1;
            if (meas_valid_d) begin
                trk_max_d = vmax_d;
                trk_min_d = vmin_d;
            end else if (timeout_d) begin
                trk_max_d = din;
                trk_min_d = din;
            end else begin
                if (din > trk_max_q) trk_max_d = din;
                if (din < trk_min_q) trk_min_d = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_max_q <= 8'h00;
            trk_min_q <= 8'hFF;
            seen_q    <= 1'b0;
        end else begin
            trk_max_q <= trk_max_d;
            trk_min_q <= trk_min_d;
            seen_q    <= seen_d;
        end
    end
`else
    always_comb begin
        thr = 8'(THRESH);
    end
`endif

    // Hysteresis band edges saturate at the 8-bit rails instead of wrapping.
    always_comb begin
        hi_sum = {2'b00, thr} + HYST_W;
        thr_hi = (hi_sum > 10'd255) ? 8'hFF : hi_sum[7:0];
        thr_lo = ({2'b00, thr} < HYST_W) ? 8'h00 : 8'({2'b00, thr} - HYST_W);
        is_high = (din >= thr_hi);
        is_low  = (din <= thr_lo);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        period_d     = period_q;
        vmax_d       = vmax_q;
        vmin_d       = vmin_q;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;

        if (sample_en) begin
            case (state_q)
                SEEK: begin
                    if (is_low) state_d = ARM;
                end
                ARM: begin
                    if (is_high) begin
                        state_d   = RUN_HI;
                        cnt_d     = CNT_ONE;
                        run_max_d = din;
                        run_min_d = din;
                    end
                end
                RUN_HI, RUN_LO: begin
                    // A crossing wins over saturation: it still closes a valid cycle.
                    if (state_q == RUN_LO && is_high) begin
                        period_d     = cnt_q;
                        vmax_d       = run_max_q;
                        vmin_d       = run_min_q;
                        meas_valid_d = 1'b1;
                        state_d      = RUN_HI;
                        cnt_d        = CNT_ONE;
                        run_max_d    = din;
                        run_min_d    = din;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = SEEK;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (din > run_max_q) run_max_d = din;
                        if (din < run_min_q) run_min_d = din;
                        if (state_q == RUN_HI && is_low) state_d = RUN_LO;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEEK;
            cnt_q        <= '0;
            run_max_q    <= 8'h00;
            run_min_q    <= 8'hFF;
            period_q     <= '0;
            vmax_q       <= 8'h00;
            vmin_q       <= 8'h00;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            period_q     <= period_d;
            vmax_q       <= vmax_d;
            vmin_q       <= vmin_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign vmax       = vmax_q;
    assign vmin       = vmin_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign locked     = (state_q == RUN_HI) || (state_q == RUN_LO);

endmodule

// File: tb/tb_wave_measure.sv
// Randomized and directed bench for wave_measure with a reference model and event scoreboard.
module tb_wave_measure;

    localparam int CNT_W  = 8;
    localparam int HYST   = 8;
    localparam int THRESH = 128;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             sample_en;
    logic [7:0]       din;
    logic [CNT_W-1:0] period;
    logic [7:0]       vmax;
    logic [7:0]       vmin;
    logic             meas_valid;
    logic             timeout;
    logic             locked;

    wave_measure #(.CNT_W(CNT_W), .HYST(HYST), .THRESH(THRESH)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din),
        .period(period), .vmax(vmax), .vmin(vmin),
        .meas_valid(meas_valid), .timeout(timeout), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_to;
        int p;
        int mx;
        int mn;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_meas_seen = 0;
    int  n_to_seen   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a cycle is "locked" once a low-then-high pattern is seen;
    // it then alternates between waiting for a low and waiting for a high.
    bit m_armed, m_running, m_wait_low;
    int m_cnt, m_rmax, m_rmin, m_pub_p, m_pub_max, m_pub_min;
    bit m_seen;
    int m_tmax, m_tmin;

    task automatic model_reset();
        m_armed = 0; m_running = 0; m_wait_low = 0;
        m_cnt = 0; m_rmax = 0; m_rmin = 255;
        m_pub_p = 0; m_pub_max = 0; m_pub_min = 0;
        m_seen = 0; m_tmax = 0; m_tmin = 255;
        exp_q.delete();
    endtask

    task automatic model_sample(input int d);
        int thr, hi, lo;
        bit ev_meas, ev_to;
        ev_t ev;
        ev_meas = 0; ev_to = 0;
        thr = THRESH;
`ifdef WAVE_MEASURE_AUTO_THRESH_EN
        if (m_seen) thr = (m_tmax + m_tmin) / 2;
`endif
        hi = (thr + HYST > 255) ? 255 : thr + HYST;
        lo = (thr - HYST < 0) ? 0 : thr - HYST;
        if (!m_running) begin
            if (!m_armed) begin
                if (d <= lo) m_armed = 1;
            end else if (d >= hi) begin
                m_running = 1; m_wait_low = 1; m_armed = 0;
                m_cnt = 1; m_rmax = d; m_rmin = d;
            end
        end else if (!m_wait_low && d >= hi) begin
            m_pub_p = m_cnt; m_pub_max = m_rmax; m_pub_min = m_rmin;
            ev_meas = 1;
            m_cnt = 1; m_rmax = d; m_rmin = d; m_wait_low = 1;
        end else if (m_cnt == CMAX) begin
            ev_to = 1;
            m_running = 0; m_armed = 0; m_cnt = 0;
        end else begin
            m_cnt++;
            if (d > m_rmax) m_rmax = d;
            if (d < m_rmin) m_rmin = d;
            if (m_wait_low && d <= lo) m_wait_low = 0;
        end
        if (ev_meas) begin
            m_tmax = m_pub_max; m_tmin = m_pub_min;
        end else if (ev_to) begin
            m_tmax = d; m_tmin = d;
        end else begin
            if (d > m_tmax) m_tmax = d;
            if (d < m_tmin) m_tmin = d;
        end
        m_seen = 1;
        if (ev_meas || ev_to) begin
            ev.is_to = ev_to; ev.p = m_pub_p; ev.mx = m_pub_max; ev.mn = m_pub_min;
            exp_q.push_back(ev);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else if (sample_en) model_sample(int'(din));
    end

    // Monitor: every expected event must coincide with exactly one DUT pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            ev_t ev;
            chk("locked", int'(locked), int'(m_running));
            if (meas_valid && timeout) chk("pulse_exclusive", 1, 0);
            if (meas_valid) n_meas_seen++;
            if (timeout) n_to_seen++;
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                chk(ev.is_to ? "timeout_pulse" : "meas_valid_pulse",
                    int'(ev.is_to ? timeout : meas_valid), 1);
                chk(ev.is_to ? "meas_valid_quiet" : "timeout_quiet",
                    int'(ev.is_to ? meas_valid : timeout), 0);
                chk("period", int'(period), ev.p);
                chk("vmax", int'(vmax), ev.mx);
                chk("vmin", int'(vmin), ev.mn);
            end else begin
                chk("spurious_meas_valid", int'(meas_valid), 0);
                chk("spurious_timeout", int'(timeout), 0);
            end
        end
    end

    task automatic put(input bit en, input int d);
        sample_en = en;
        din = 8'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input int d, input int gap);
        repeat (gap) put(1'b0, int'($urandom_range(0, 255)));
        put(1'b1, d);
    endtask

    task automatic square(input int lo_v, input int hi_v, input int half, input int cycles, input int gap);
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < half; k++) acc(lo_v, gap);
            for (int k = 0; k < half; k++) acc(hi_v, gap);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_vmax"}, int'(vmax), 0);
        chk({tag, "_vmin"}, int'(vmin), 0);
        chk({tag, "_meas_valid"}, int'(meas_valid), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_locked"}, int'(locked), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base_meas, base_to;
        int t0, t1;
        rst_n = 1'b0; sample_en = 1'b0; din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("por");
        rst_n = 1'b1;

        // Square wave, every clock accepted.
        square(8'h20, 8'hE0, 5, 6, 0);
        put(0, 0); put(0, 0);
        chk("sq_period", int'(period), 10);
        chk("sq_vmax", int'(vmax), 8'hE0);
        chk("sq_vmin", int'(vmin), 8'h20);
        chk("sq_meas_count", n_meas_seen, 5);

        // Same wave, one clock in three, garbage on idle clocks; meas_valid every 30 clocks.
        base_meas = n_meas_seen;
        square(8'h20, 8'hE0, 5, 4, 2);
        t0 = n_meas_seen;
        repeat (30) put(0, int'($urandom_range(0, 255)));
        chk("sparse_idle_no_meas", n_meas_seen, t0);
        chk("sparse_period", int'(period), 10);
        chk("sparse_meas_count", n_meas_seen - base_meas, 4);

        // Noise inside the hysteresis band never locks.
        pulse_reset();
        base_meas = n_meas_seen;
        for (int i = 0; i < 100; i++) acc((i % 2) ? 8'h85 : 8'h7B, 0);
        chk("noise_locked", int'(locked), 0);
        chk("noise_meas", n_meas_seen, base_meas);

        // One crossing, then a flat high level saturates the counter.
        pulse_reset();
        base_to = n_to_seen;
        acc(8'h20, 0);
        acc(8'hE0, 0);
        for (int i = 0; i < 254; i++) acc(8'hE0, 0);
        t1 = n_to_seen;
        acc(8'hE0, 0);
        put(0, 0); put(0, 0);
        chk("to_not_early", t1, base_to);
        chk("to_count", n_to_seen - base_to, 1);
        chk("to_period_kept", int'(period), 0);
        chk("to_unlocked", int'(locked), 0);

        // Crossing exactly at saturation is a measurement of all-ones.
        pulse_reset();
        base_to = n_to_seen;
        acc(8'h20, 0);
        acc(8'hE0, 0);
        for (int i = 0; i < 99; i++) acc(8'hE0, 0);
        for (int i = 0; i < 155; i++) acc(8'h20, 0);
        acc(8'hE0, 0);
        put(0, 0); put(0, 0);
        chk("sat_cross_period", int'(period), CMAX);
        chk("sat_cross_no_to", n_to_seen, base_to);

        // Reset mid RUN_LO; first report needs two fresh crossings.
        square(8'h20, 8'hE0, 5, 2, 0);
        acc(8'h20, 0); acc(8'h20, 0);
        pulse_reset();
        base_meas = n_meas_seen;
        square(8'h20, 8'hE0, 5, 1, 0);
        chk("post_reset_one_cross", n_meas_seen, base_meas);
        square(8'h20, 8'hE0, 5, 1, 0);
        put(0, 0); put(0, 0);
        chk("post_reset_two_cross", n_meas_seen - base_meas, 1);
        chk("post_reset_period", int'(period), 10);

        // Triangle 0x00..0x40..0x00, 128 samples per period.
        pulse_reset();
        base_meas = n_meas_seen;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 128; i++) acc((i <= 64) ? i : 128 - i, 0);
        put(0, 0); put(0, 0);
`ifdef WAVE_MEASURE_AUTO_THRESH_EN
        chk("tri_period", int'(period), 128);
        chk("tri_vmax", int'(vmax), 8'h40);
        chk("tri_vmin", int'(vmin), 8'h00);
`else
        chk("tri_locked", int'(locked), 0);
        chk("tri_meas", n_meas_seen, base_meas);
`endif

        // Randomized square-ish waves with jitter and sparse sampling.
        for (int s = 0; s < 40; s++) begin
            int lo_v, hi_v, half, gap;
            lo_v = int'($urandom_range(0, 110));
            hi_v = int'($urandom_range(146, 255));
            half = int'($urandom_range(1, 12));
            gap  = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) pulse_reset();
            for (int c = 0; c < 3; c++) begin
                for (int k = 0; k < half; k++) acc(lo_v + int'($urandom_range(0, 10)), gap);
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) acc(int'($urandom_range(115, 140)), gap);
                for (int k = 0; k < half; k++) acc(hi_v - int'($urandom_range(0, 10)), gap);
            end
        end

        put(0, 0); put(0, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
